// File: rtl/obstacle_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_pkg
// Shared definitions for the obstacle scheduler slice: slot field widths,
// game-phase encoding, obstacle sprite types and the LFSR step function.
// -----------------------------------------------------------------------------
package obstacle_pkg;

    localparam int POS_W  = 10;
    localparam int TYPE_W = 2;
    localparam int LFSR_W = 8;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } game_state_e;

    typedef enum logic [TYPE_W-1:0] {
        CACTUS_S = 2'd0,
        CACTUS_L = 2'd1,
        CACTUS_G = 2'd2,
        BIRD     = 2'd3
    } obstacle_type_e;

    // One shift-left step; the XOR of the tapped bits feeds bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        lfsr_step = {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// -----------------------------------------------------------------------------
// obstacle_lfsr
// 8-bit Fibonacci LFSR used for spawn spacing and obstacle type selection.
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset (loads SEED)
//   advance in   step the register by one position
//   value   out  current LFSR contents
// -----------------------------------------------------------------------------
module obstacle_lfsr
    import obstacle_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    // Shift register: seed on reset, one step per advance strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
// Owns the two on-screen obstacle slots: per-tick movement, despawn, LFSR
// randomised spawn spacing, spawn arbitration and the IDLE/RUN/HALT phase FSM.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   game_tick            one-cycle frame strobe
//   start, crash         start request / collision detected
//   speed[2:0]           pixels moved per tick
//   obstacle1/2_pos      slot x positions (0 when inactive)
//   obstacle1/2_type     slot sprite types
//   obstacle_active[1:0] bit0 = slot 1, bit1 = slot 2
//   spawn_pulse          one-cycle strobe when a slot is claimed
//   game_frozen          high in IDLE and HALT
// Build option: OBSTACLE_SCHED_SPEEDUP_EN adds a saturating level bonus to
// the speed, bumped after every 16th spawn.
// -----------------------------------------------------------------------------
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter logic [POS_W-1:0]  SPAWN_X   = 10'd640,
    parameter logic [7:0]        FIRST_GAP = 8'd20,
    parameter logic [7:0]        MIN_GAP   = 8'd40,
    parameter logic [7:0]        GAP_MASK  = 8'h3F,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              game_tick,
    input  logic              start,
    input  logic              crash,
    input  logic [2:0]        speed,
    output logic [POS_W-1:0]  obstacle1_pos,
    output logic [POS_W-1:0]  obstacle2_pos,
    output logic [TYPE_W-1:0] obstacle1_type,
    output logic [TYPE_W-1:0] obstacle2_type,
    output logic [1:0]        obstacle_active,
    output logic              spawn_pulse,
    output logic              game_frozen
);

    game_state_e        state_r;
    logic [POS_W-1:0]   pos_r  [2];
    logic [TYPE_W-1:0]  type_r [2];
    logic [1:0]         active_r;
    logic [7:0]         gap_r;
    logic               pulse_r;
    logic               frozen_r;

    logic [LFSR_W-1:0]  lfsr_s;
    logic [2:0]         eff_speed_s;
    logic [POS_W-1:0]   step_pos_s [2];
    logic [1:0]         step_active_s;
    logic [7:0]         step_gap_s;
    logic               spawn_s;
    logic               spawn_idx_s;
    logic               enter_run_s;
    logic               do_step_s;

    obstacle_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (game_tick),
        .value   (lfsr_s)
    );

`ifdef OBSTACLE_SCHED_SPEEDUP_EN
    logic [2:0] level_r;
    logic [3:0] spawn_cnt_r;
    logic [3:0] speed_sum_s;

    // Effective speed is speed plus level bonus, clamped to 7.
    always_comb begin
        speed_sum_s = {1'b0, speed} + {1'b0, level_r};
        if (speed_sum_s > 4'd7) begin
            eff_speed_s = 3'd7;
        end else begin
            eff_speed_s = speed_sum_s[2:0];
        end
    end

    // Level tracking: the 4-bit spawn counter wraps every 16 spawns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_r     <= 3'd0;
            spawn_cnt_r <= 4'd0;
        end else if (enter_run_s) begin
            level_r     <= 3'd0;
            spawn_cnt_r <= 4'd0;
        end else if (do_step_s && spawn_s) begin
            spawn_cnt_r <= spawn_cnt_r + 4'd1;
            if ((spawn_cnt_r == 4'd15) && (level_r != 3'd7)) begin
                level_r <= level_r + 3'd1;
            end
        end
    end
`else
    assign eff_speed_s = speed;
`endif

    // Tick step results: movement/despawn, gap countdown and spawn decision,
    // all judged on the slot/counter state at the start of the tick.
    always_comb begin
        enter_run_s = ((state_r == IDLE) || (state_r == HALT)) && start;
        do_step_s   = (state_r == RUN) && !crash && game_tick;
        for (int i = 0; i < 2; i++) begin
            if (active_r[i] && (pos_r[i] > {7'd0, eff_speed_s})) begin
                step_pos_s[i]    = pos_r[i] - {7'd0, eff_speed_s};
                step_active_s[i] = 1'b1;
            end else begin
                step_pos_s[i]    = {POS_W{1'b0}};
                step_active_s[i] = 1'b0;
            end
        end
        // A slot freed during this tick is not counted as free here.
        spawn_s     = (gap_r == 8'd0) && (active_r != 2'b11);
        spawn_idx_s = active_r[0];
        if (spawn_s) begin
            step_gap_s = MIN_GAP + (lfsr_s & GAP_MASK);
        end else if (gap_r != 8'd0) begin
            step_gap_s = gap_r - 8'd1;
        end else begin
            step_gap_s = gap_r;
        end
    end

    // Phase FSM and slot registers; all outputs are driven from these.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            frozen_r <= 1'b1;
            pulse_r  <= 1'b0;
            active_r <= 2'b00;
            gap_r    <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                pos_r[i]  <= {POS_W{1'b0}};
                type_r[i] <= CACTUS_S;
            end
        end else begin
            pulse_r <= 1'b0;
            case (state_r)
                IDLE, HALT: begin
                    // In HALT start wins over a simultaneous crash.
                    if (start) begin
                        state_r  <= RUN;
                        frozen_r <= 1'b0;
                        active_r <= 2'b00;
                        gap_r    <= FIRST_GAP;
                        for (int i = 0; i < 2; i++) begin
                            pos_r[i]  <= {POS_W{1'b0}};
                            type_r[i] <= CACTUS_S;
                        end
                    end
                end
                RUN: begin
                    // Crash wins over start and suppresses the tick step.
                    if (crash) begin
                        state_r  <= HALT;
                        frozen_r <= 1'b1;
                    end else if (game_tick) begin
                        active_r <= step_active_s;
                        gap_r    <= step_gap_s;
                        for (int i = 0; i < 2; i++) begin
                            pos_r[i] <= step_pos_s[i];
                        end
                        if (spawn_s) begin
                            active_r[spawn_idx_s] <= 1'b1;
                            pos_r[spawn_idx_s]    <= SPAWN_X;
                            type_r[spawn_idx_s]   <= lfsr_s[TYPE_W-1:0];
                            pulse_r               <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    frozen_r <= 1'b1;
                end
            endcase
        end
    end

    assign obstacle1_pos   = pos_r[0];
    assign obstacle2_pos   = pos_r[1];
    assign obstacle1_type  = type_r[0];
    assign obstacle2_type  = type_r[1];
    assign obstacle_active = active_r;
    assign spawn_pulse     = pulse_r;
    assign game_frozen     = frozen_r;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_obstacle_scheduler
// Self-checking bench for obstacle_scheduler: directed scenarios plus a
// randomised run, all checked against a behavioural game model.
// -----------------------------------------------------------------------------
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game_tick;
    logic       start;
    logic       crash;
    logic [2:0] speed;
    logic [9:0] obstacle1_pos;
    logic [9:0] obstacle2_pos;
    logic [1:0] obstacle1_type;
    logic [1:0] obstacle2_type;
    logic [1:0] obstacle_active;
    logic       spawn_pulse;
    logic       game_frozen;

    obstacle_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .game_tick       (game_tick),
        .start           (start),
        .crash           (crash),
        .speed           (speed),
        .obstacle1_pos   (obstacle1_pos),
        .obstacle2_pos   (obstacle2_pos),
        .obstacle1_type  (obstacle1_type),
        .obstacle2_type  (obstacle2_type),
        .obstacle_active (obstacle_active),
        .spawn_pulse     (spawn_pulse),
        .game_frozen     (game_frozen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    int m_phase;          // 0 idle, 1 running, 2 halted
    int m_pos  [2];
    int m_type [2];
    bit m_act  [2];
    int m_gap;
    int m_lfsr;
    bit m_pulse;
    int m_spawns;         // spawns since the game (re)started
    int m_reload;         // last gap loaded on a spawn

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l * 2) % 256) + fb;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_gap = 0; m_lfsr = 165; m_pulse = 0; m_spawns = 0; m_reload = 0;
        for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_type[i] = 0; m_act[i] = 0; end
    endtask

    task automatic model_cycle(input bit r, input bit tk, input bit st, input bit cr, input int spd);
        int pre, eff, k;
        bit was_zero;
        bit was_free [2];
        if (!r) begin model_reset(); return; end
        pre = m_lfsr;
        m_pulse = 0;
        if (tk) m_lfsr = lfsr_next(pre);
        if ((m_phase == 0 || m_phase == 2) && st) begin
            m_phase = 1; m_gap = 20; m_spawns = 0;
            for (int i = 0; i < 2; i++) begin m_pos[i] = 0; m_type[i] = 0; m_act[i] = 0; end
        end else if (m_phase == 1 && cr) begin
            m_phase = 2;
        end else if (m_phase == 1 && tk) begin
            eff = spd;
`ifdef OBSTACLE_SCHED_SPEEDUP_EN
            eff = spd + m_spawns / 16;
            if (eff > 7) eff = 7;
`endif
            was_zero = (m_gap == 0);
            for (int i = 0; i < 2; i++) begin
                was_free[i] = !m_act[i];
                if (m_act[i]) begin
                    if (m_pos[i] > eff) m_pos[i] = m_pos[i] - eff;
                    else begin m_pos[i] = 0; m_act[i] = 0; end
                end
            end
            if (m_gap != 0) m_gap = m_gap - 1;
            if (was_zero && (was_free[0] || was_free[1])) begin
                k = was_free[0] ? 0 : 1;
                m_act[k] = 1; m_pos[k] = 640; m_type[k] = pre % 4;
                m_reload = 40 + (pre % 64);
                m_gap = m_reload;
                m_pulse = 1;
                m_spawns++;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit r, input bit tk, input bit st, input bit cr, input int spd);
        rst_n = r; game_tick = tk; start = st; crash = cr; speed = 3'(spd);
        model_cycle(r, tk, st, cr, spd);
        @(posedge clk);
        #1;
        rst_n = 1'b1; game_tick = 1'b0; start = 1'b0; crash = 1'b0;
    endtask

    task automatic do_tick(input int spd);
        step(1'b1, 1'b1, 1'b0, 1'b0, spd);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bad_pulse, bad_frozen;
        do_reset();
        n_checks++;
        if ({obstacle_active, obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, spawn_pulse} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: act=%b p1=%0d p2=%0d t1=%0d t2=%0d pulse=%b, expected all zero",
                     obstacle_active, obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, spawn_pulse);
        end
        n_checks++;
        if (game_frozen !== 1'b1) begin
            n_fail++; $display("FAIL reset_frozen: got %b expected 1", game_frozen);
        end
        bad_pulse = 0; bad_frozen = 0;
        for (int i = 0; i < 100; i++) begin
            do_tick($urandom_range(7, 0));
            if (spawn_pulse !== 1'b0) bad_pulse++;
            if (game_frozen !== 1'b1) bad_frozen++;
        end
        n_checks++;
        if (bad_pulse != 0) begin
            n_fail++; $display("FAIL idle_no_spawn: %0d pulses seen in IDLE, expected 0", bad_pulse);
        end
        n_checks++;
        if (bad_frozen != 0) begin
            n_fail++; $display("FAIL idle_frozen: %0d cycles unfrozen in IDLE, expected 0", bad_frozen);
        end
    endtask

    task automatic test_first_spawn();
        int early;
        step(1'b1, 1'b0, 1'b1, 1'b0, 4);
        n_checks++;
        if (game_frozen !== 1'b0) begin
            n_fail++; $display("FAIL start_unfreeze: got %b expected 0", game_frozen);
        end
        early = 0;
        for (int i = 0; i < 20; i++) begin
            do_tick(4);
            if (spawn_pulse !== 1'b0) early++;
            step(1'b1, 1'b0, 1'b0, 1'b0, 4);
        end
        n_checks++;
        if (early != 0) begin
            n_fail++; $display("FAIL first_gap_early: %0d pulses in first 20 ticks, expected 0", early);
        end
        do_tick(4);
        n_checks++;
        if ({spawn_pulse, obstacle_active, obstacle1_pos} !== {1'b1, 2'b01, 10'd640}) begin
            n_fail++;
            $display("FAIL first_spawn: pulse=%b act=%b p1=%0d, expected pulse=1 act=01 p1=640",
                     spawn_pulse, obstacle_active, obstacle1_pos);
        end
        n_checks++;
        if (obstacle1_type !== 2'(m_type[0])) begin
            n_fail++; $display("FAIL first_type: got %0d expected %0d", obstacle1_type, m_type[0]);
        end
        do_tick(4);
        n_checks++;
        if ({spawn_pulse, obstacle1_pos, game_frozen} !== {1'b0, 10'd636, 1'b0}) begin
            n_fail++;
            $display("FAIL first_move: pulse=%b p1=%0d frozen=%b, expected pulse=0 p1=636 frozen=0",
                     spawn_pulse, obstacle1_pos, game_frozen);
        end
    endtask

    task automatic test_spacing();
        int cnt, gap, extra;
        bit got;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 21; i++) do_tick(0);
        gap = m_reload;
        n_checks++;
        if ({spawn_pulse, obstacle_active} !== 3'b101) begin
            n_fail++; $display("FAIL spacing_first: pulse=%b act=%b expected 1/01", spawn_pulse, obstacle_active);
        end
        cnt = 0; got = 0;
        while (!got && cnt < 300) begin
            do_tick(0); cnt++;
            if (spawn_pulse === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || cnt != gap + 1) begin
            n_fail++; $display("FAIL spawn_spacing: second spawn after %0d ticks, expected %0d", cnt, gap + 1);
        end
        n_checks++;
        if ({obstacle_active, obstacle2_pos} !== {2'b11, 10'd640}) begin
            n_fail++; $display("FAIL second_slot: act=%b p2=%0d expected 11/640", obstacle_active, obstacle2_pos);
        end
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            do_tick(0);
            if (spawn_pulse !== 1'b0 || obstacle_active !== 2'b11) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL blocked_spawn: %0d bad cycles with both slots busy, expected 0", extra);
        end
    endtask

    task automatic test_despawn_respawn();
        int guard;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 21; i++) do_tick(0);
        guard = 0;
        do begin do_tick(1); guard++; end while (!m_pulse && guard < 300);
        guard = 0;
        while (m_pos[0] > 10 && guard < 300) begin do_tick(7); guard++; end
        if (m_pos[0] > 3) do_tick(m_pos[0] - 3);
        guard = 0;
        while (m_gap != 0 && guard < 300) begin do_tick(0); guard++; end
        n_checks++;
        if ({obstacle_active, obstacle1_pos} !== {2'b11, 10'd3}) begin
            n_fail++; $display("FAIL despawn_setup: act=%b p1=%0d expected 11/3", obstacle_active, obstacle1_pos);
        end
        do_tick(4);
        n_checks++;
        if ({spawn_pulse, obstacle_active, obstacle1_pos} !== {1'b0, 2'b10, 10'd0}) begin
            n_fail++;
            $display("FAIL despawn: pulse=%b act=%b p1=%0d expected 0/10/0", spawn_pulse, obstacle_active, obstacle1_pos);
        end
        do_tick(4);
        n_checks++;
        if ({spawn_pulse, obstacle_active, obstacle1_pos} !== {1'b1, 2'b11, 10'd640}) begin
            n_fail++;
            $display("FAIL respawn: pulse=%b act=%b p1=%0d expected 1/11/640", spawn_pulse, obstacle_active, obstacle1_pos);
        end
    endtask

    task automatic test_crash_halt();
        logic [9:0] held;
        int moved, early;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 3);
        for (int i = 0; i < 20; i++) do_tick(3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3);
        n_checks++;
        if ({spawn_pulse, obstacle_active, game_frozen} !== {1'b0, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL crash_no_spawn: pulse=%b act=%b frozen=%b expected 0/00/1", spawn_pulse, obstacle_active, game_frozen);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 3);
        for (int i = 0; i < 26; i++) do_tick(3);
        held = obstacle1_pos;
        n_checks++;
        if (held !== 10'd625) begin
            n_fail++; $display("FAIL pre_crash_pos: got %0d expected 625", held);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 3);
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick(5);
            if (obstacle1_pos !== held || spawn_pulse !== 1'b0 || game_frozen !== 1'b1) moved++;
        end
        n_checks++;
        if (moved != 0) begin
            n_fail++; $display("FAIL halt_freeze: %0d cycles changed while halted, expected 0", moved);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 3);
        n_checks++;
        if ({game_frozen, obstacle_active, obstacle1_pos, obstacle2_pos} !== 23'd0) begin
            n_fail++;
            $display("FAIL restart_clear: frozen=%b act=%b p1=%0d p2=%0d expected all 0",
                     game_frozen, obstacle_active, obstacle1_pos, obstacle2_pos);
        end
        early = 0;
        for (int i = 0; i < 20; i++) begin
            do_tick(3);
            if (spawn_pulse !== 1'b0) early++;
        end
        do_tick(3);
        n_checks++;
        if (early != 0 || spawn_pulse !== 1'b1) begin
            n_fail++; $display("FAIL restart_gap: early=%0d pulse=%b, expected 0 early and pulse on tick 21", early, spawn_pulse);
        end
    endtask

`ifdef OBSTACLE_SCHED_SPEEDUP_EN
    task automatic test_speedup();
        logic [9:0] prev;
        int guard;
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 6);
        for (int target = 16; target <= 32; target += 16) begin
            guard = 0;
            while (!(m_spawns >= target && m_act[0] && m_pos[0] > 20) && guard < 20000) begin
                do_tick(6); guard++;
            end
            prev = obstacle1_pos;
            do_tick(6);
            n_checks++;
            if (prev - obstacle1_pos !== 10'd7) begin
                n_fail++; $display("FAIL speedup_%0d: moved %0d expected 7", target, prev - obstacle1_pos);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [27:0] got, exp;
        int bad;
        bit r, tk, st, cr;
        do_reset();
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(399, 0) != 0);
            tk = $urandom_range(1, 0);
            st = ($urandom_range(19, 0) == 0);
            cr = ($urandom_range(59, 0) == 0);
            step(r, tk, st, cr, $urandom_range(7, 0));
            got = {obstacle_active, obstacle1_pos, obstacle2_pos, obstacle1_type, obstacle2_type, spawn_pulse, game_frozen};
            exp = {m_act[1], m_act[0], 10'(m_pos[0]), 10'(m_pos[1]), 2'(m_type[0]), 2'(m_type[1]),
                   m_pulse, (m_phase != 1)};
            n_checks++;
            if (got !== exp) begin
                n_fail++; bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; game_tick = 1'b0; start = 1'b0; crash = 1'b0; speed = 3'd0;
        model_reset();
        test_reset();
        test_first_spawn();
        test_spacing();
        test_despawn_respawn();
        test_crash_halt();
`ifdef OBSTACLE_SCHED_SPEEDUP_EN
        test_speedup();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Owns the two on-screen obstacle slots consumed by the renderer, collision logic and ai_controller.
- Sequences per-game-tick movement, despawn and LFSR-randomised spawn spacing.
- Arbitrates the single spawn event between the two slots.
- Runs a small game-phase FSM (IDLE/RUN/HALT) driven by start and crash.

Parameters:
- SPAWN_X, 640, x position loaded into a slot on spawn (10-bit).
- FIRST_GAP, 20, ticks from start to first spawn.
- MIN_GAP, 40, minimum ticks between spawns.
- GAP_MASK, 8'h3F, mask applied to LFSR for the random gap component. MIN_GAP+GAP_MASK must be ≤ 255.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- game_tick  in  1  one-cycle frame-rate strobe
- start  in  1  start request (button_start)
- crash  in  1  collision detected
- speed  in  3  pixels moved per tick
- obstacle1_pos  out  10  slot 1 x position, 0 when inactive
- obstacle2_pos  out  10  slot 2 x position, 0 when inactive
- obstacle1_type  out  2  slot 1 sprite type
- obstacle2_type  out  2  slot 2 sprite type
- obstacle_active  out  2  bit0 = slot 1, bit1 = slot 2
- spawn_pulse  out  1  one-cycle strobe on spawn
- game_frozen  out  1  high in IDLE and HALT

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk, rising edge.
  - All outputs 0 except game_frozen = 1.
  - State IDLE; gap counter 0; LFSR = LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit0. Advances on every game_tick in every state.
- FSM, any cycle (not tick-gated):
  - IDLE --start--> RUN.
  - RUN --crash--> HALT.
  - HALT --start--> RUN.
  - Entering RUN: clear both slots (active = 0, pos = 0, type = 0) and load gap counter with FIRST_GAP.
- Same-cycle priority:
  - RUN: crash beats start.
  - HALT: start beats crash.
- HALT freezes positions, types and counter exactly as they were at crash.
- RUN, on game_tick with no crash that cycle, steps in order:
  1. Move: each active slot with pos > speed becomes pos − speed. Active slot with pos ≤ speed becomes inactive, pos 0 (despawn). speed = 0 means no movement.
  2. Gap: if counter ≠ 0, decrement.
  3. Spawn: if counter was already 0 at tick start and a slot was free at tick start:
     - Claim lowest-index free slot: active = 1, pos = SPAWN_X, type = LFSR[1:0] (pre-advance value).
     - Reload counter with MIN_GAP + (LFSR & GAP_MASK), pre-advance value.
     - spawn_pulse = 1 for that cycle.
- A slot freed on a tick is not spawnable until the next tick.
- Counter at 0 with no free slot holds at 0; spawn occurs on the first tick after a slot frees.
- Latency: registered outputs update the cycle after game_tick.
- Non-tick cycles: no change except FSM/start/crash handling.
- Mid-game reset returns to IDLE with the reset values above.

Optional Feature:
- Macro: OBSTACLE_SCHED_SPEEDUP_EN.
- Defined:
  - Effective speed = min(7, speed + level).
  - level is a 3-bit saturating counter, incremented after every 16th spawn, cleared on entering RUN.
- Undefined:
  - Effective speed = speed.
  - No level register.

Decomposition:
- Shared package obstacle_pkg:
  - POS_W = 10, TYPE_W = 2.
  - State encoding IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - LFSR tap constant.
  - Obstacle type enumeration (CACTUS_S, CACTUS_L, CACTUS_G, BIRD).
- Sub-module: obstacle_lfsr (8-bit, seed param, advance enable). The slot logic stays in the top module.

Test Plan:
1. Reset 5 cycles -> all pos/type/active 0, game_frozen = 1, spawn_pulse never asserts over 100 ticks without start.
2. start, speed = 4, then 20 ticks -> spawn_pulse on 21st tick; slot 1 pos = 640; next tick pos = 636; game_frozen = 0.
3. GAP_MASK = 0, MIN_GAP = 40, speed = 0 -> second spawn into slot 2 exactly 41 ticks after first. Third spawn is blocked; counter holds 0; no pulse.
4. Slot 1 pos = 3, speed = 4, counter = 0, slot 2 busy -> slot 1 despawns (pos 0, active[0] = 0) that tick; spawn into slot 1 on following tick.
5. crash asserted same cycle as game_tick in RUN -> positions unchanged, state HALT, no spawn. Then start + crash same cycle -> RUN, slots cleared, counter = FIRST_GAP.
6. With OBSTACLE_SCHED_SPEEDUP_EN, speed = 6 -> after 16 spawns movement is 7/tick; after 32 spawns movement is still 7 (saturated).
